// File: rtl/qspi_rx_pkg.sv
// rtl/qspi_rx_pkg.sv - shared constants for the QSPI receive FIFO
package qspi_rx_pkg;

    localparam int BYTES_PER_WORD       = 4;
    localparam int DEFAULT_FIFO_DEPTH   = 16;
    localparam int LEVEL_W              = 5;   // width of the rx_level / rx_thresh fields
    localparam int ERR_STAT_OVERRUN_BIT = 3;

    // Word counter width: must hold 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/qspi_rx_packer.sv
// rtl/qspi_rx_packer.sv - packs received bytes into little-endian 32-bit words
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rx_byte_valid   strobe: rx_byte holds a received byte
//   rx_byte         received byte
//   rx_flush        end-of-transfer: push whatever is packed
//   push            combinational push strobe toward the word FIFO
//   push_word       word to push (unused upper lanes are zero)
//   bidx            byte index 0..3 (number of bytes held)
module qspi_rx_packer
    import qspi_rx_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx_byte_valid,
    input  logic [7:0]                  rx_byte,
    input  logic                        rx_flush,
    output logic                        push,
    output logic [BYTES_PER_WORD*8-1:0] push_word,
    output logic [1:0]                  bidx
);

    logic [BYTES_PER_WORD*8-1:0] pack;
    logic [BYTES_PER_WORD*8-1:0] merged;

    // The incoming byte is merged before the push decision so a byte arriving
    // together with a flush is part of the flushed word.
    always_comb begin
        merged = pack;
        if (rx_byte_valid) begin
            merged[{bidx, 3'b000} +: 8] = rx_byte;
        end
    end

    assign push      = (rx_byte_valid && (bidx == 2'd3)) ||
                       (rx_flush && ((bidx != 2'd0) || rx_byte_valid));
    assign push_word = merged;

    // Packer returns to empty after any push, even if the FIFO drops the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack <= '0;
            bidx <= 2'd0;
        end else if (push) begin
            pack <= '0;
            bidx <= 2'd0;
        end else if (rx_byte_valid) begin
            pack <= merged;
            bidx <= bidx + 2'd1;
        end
    end

endmodule

// File: rtl/qspi_rx_fifo.sv
// rtl/qspi_rx_fifo.sv - QSPI receive byte packer plus word FIFO with level and overrun
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rx_byte_valid   byte strobe from the QSPI FSM; rx_byte is the byte
//   rx_flush        end-of-transfer strobe; pushes a partial word
//   fifo_rx_re      read strobe on the FIFO_RX data register (pops head)
//   fifo_rx_rdata   show-ahead head word, 0 when empty
//   rx_empty/full   FIFO flags
//   rx_level        word count 0..FIFO_DEPTH
//   rx_pend_bytes   bytes held in the packer
//   overrun         sticky dropped-word flag; overrun_clr clears it
//   rx_thresh       level threshold for rx_thresh_irq
//   rx_thresh_irq   registered level >= threshold interrupt
//
// Build option: QSPI_RX_THRESH_IRQ_EN enables the threshold interrupt;
// otherwise rx_thresh_irq is 0 and rx_thresh is ignored.
module qspi_rx_fifo
    import qspi_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_byte_valid,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_flush,
    input  logic                  fifo_rx_re,
    output logic [DATA_WIDTH-1:0] fifo_rx_rdata,
    output logic                  rx_empty,
    output logic                  rx_full,
    output logic [LEVEL_W-1:0]    rx_level,
    output logic [1:0]            rx_pend_bytes,
    output logic                  overrun,
    input  logic                  overrun_clr,
    input  logic [LEVEL_W-1:0]    rx_thresh,
    output logic                  rx_thresh_irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = level_width(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic                  push;
    logic [DATA_WIDTH-1:0] push_word;
    logic [1:0]            bidx;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic                  do_read;
    logic                  do_push;
    logic                  drop;

    qspi_rx_packer u_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_byte_valid (rx_byte_valid),
        .rx_byte       (rx_byte),
        .rx_flush      (rx_flush),
        .push          (push),
        .push_word     (push_word),
        .bidx          (bidx)
    );

    assign rx_empty = (count == '0);
    assign rx_full  = (count == FULL_CNT);

    // A read in the same cycle frees the slot, so a push at full is still accepted.
    assign do_read = fifo_rx_re && !rx_empty;
    assign do_push = push && (!rx_full || do_read);
    assign drop    = push && !do_push;

    always_comb begin
        count_next = count;
        case ({do_push, do_read})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    // Storage is not reset; the empty flag masks stale contents on rdata.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    assign fifo_rx_rdata = rx_empty ? '0 : mem[rd_ptr];
    assign rx_level      = LEVEL_W'(count);
    assign rx_pend_bytes = bidx;

`ifdef QSPI_RX_THRESH_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_thresh_irq <= 1'b0;
        end else begin
            rx_thresh_irq <= (rx_thresh != '0) && (LEVEL_W'(count_next) >= rx_thresh);
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^rx_thresh;
    assign rx_thresh_irq = 1'b0;
`endif

endmodule

// File: tb/tb_qspi_rx_fifo.sv
// tb/tb_qspi_rx_fifo.sv - self-checking bench for qspi_rx_fifo
module tb_qspi_rx_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_byte_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_flush = 1'b0;
    logic        fifo_rx_re = 1'b0;
    logic [31:0] fifo_rx_rdata;
    logic        rx_empty;
    logic        rx_full;
    logic [4:0]  rx_level;
    logic [1:0]  rx_pend_bytes;
    logic        overrun;
    logic        overrun_clr = 1'b0;
    logic [4:0]  rx_thresh = 5'd0;
    logic        rx_thresh_irq;

    int checks = 0;
    int errors = 0;

    qspi_rx_fifo #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_byte_valid (rx_byte_valid),
        .rx_byte       (rx_byte),
        .rx_flush      (rx_flush),
        .fifo_rx_re    (fifo_rx_re),
        .fifo_rx_rdata (fifo_rx_rdata),
        .rx_empty      (rx_empty),
        .rx_full       (rx_full),
        .rx_level      (rx_level),
        .rx_pend_bytes (rx_pend_bytes),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr),
        .rx_thresh     (rx_thresh),
        .rx_thresh_irq (rx_thresh_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of words plus a list of pending bytes.
    logic [31:0] mq[$];
    logic [7:0]  mp[$];
    bit          m_ovr;
    bit          m_irq;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mp.delete();
            m_ovr = 1'b0;
            m_irq = 1'b0;
        end else begin
            logic [31:0] w;
            bit          set_ovr;
            set_ovr = 1'b0;
            if (fifo_rx_re && mq.size() > 0) void'(mq.pop_front());
            if (rx_byte_valid) mp.push_back(rx_byte);
            if (mp.size() == 4 || (rx_flush && mp.size() > 0)) begin
                w = '0;
                foreach (mp[i]) w = w | (32'(mp[i]) << (8 * i));
                if (mq.size() < DEPTH) mq.push_back(w);
                else set_ovr = 1'b1;
                mp.delete();
            end
            if (set_ovr) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;
`ifdef QSPI_RX_THRESH_IRQ_EN
            m_irq = (rx_thresh != 0) && (mq.size() >= int'(rx_thresh));
`else
            m_irq = 1'b0;
`endif
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("rdata", fifo_rx_rdata, (mq.size() > 0) ? mq[0] : 32'h0);
        check("level", 32'(rx_level), 32'(mq.size()));
        check("empty", 32'(rx_empty), 32'(mq.size() == 0));
        check("full", 32'(rx_full), 32'(mq.size() == DEPTH));
        check("pend", 32'(rx_pend_bytes), 32'(mp.size()));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("irq", 32'(rx_thresh_irq), 32'(m_irq));
    end

    task automatic step(input logic v, input logic [7:0] b, input logic f,
                        input logic re, input logic clr);
        rx_byte_valid = v;
        rx_byte       = b;
        rx_flush      = f;
        fifo_rx_re    = re;
        overrun_clr   = clr;
        @(posedge clk);
        #1;
        rx_byte_valid = 1'b0;
        rx_flush      = 1'b0;
        fifo_rx_re    = 1'b0;
        overrun_clr   = 1'b0;
    endtask

    task automatic put_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) step(1'b1, w[8*k +: 8], 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] fill_word(input int i);
        return {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", fifo_rx_rdata, 32'h0);
        check("reset_empty", 32'(rx_empty), 32'd1);
        check("reset_level", 32'(rx_level), 32'd0);
        check("reset_irq", 32'(rx_thresh_irq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full word from four bytes.
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        check("pend_3", 32'(rx_pend_bytes), 32'd3);
        check("level_before_push", 32'(rx_level), 32'd0);
        step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        check("word_4bytes", fifo_rx_rdata, 32'h44332211);
        check("level_1", 32'(rx_level), 32'd1);
        check("pend_0", 32'(rx_pend_bytes), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("level_after_read", 32'(rx_level), 32'd0);

        // Partial word flush.
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("flush_word", fifo_rx_rdata, 32'h0000BBAA);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Flush with nothing packed.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("flush_empty_level", 32'(rx_level), 32'd0);

        // Byte together with flush.
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
        check("byte_flush_word", fifo_rx_rdata, 32'h0000CCAA);
        check("byte_flush_level", 32'(rx_level), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Fill, overflow, drain, clear.
        for (int i = 0; i < DEPTH; i++) put_word(fill_word(i));
        check("full_level", 32'(rx_level), 32'd16);
        check("full_flag", 32'(rx_full), 32'd1);
        put_word(32'hDEADBEEF);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_level", 32'(rx_level), 32'd16);
        check("ovr_pend", 32'(rx_pend_bytes), 32'd0);
        check("head_0", fifo_rx_rdata, 32'h04030201);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_word", fifo_rx_rdata, fill_word(i));
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        check("drained_empty", 32'(rx_empty), 32'd1);
        check("ovr_sticky", 32'(overrun), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("ovr_clr", 32'(overrun), 32'd0);

        // Push and read together while full.
        for (int i = 0; i < DEPTH; i++) put_word(fill_word(i));
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        check("full_rw_level", 32'(rx_level), 32'd16);
        check("full_rw_head", fifo_rx_rdata, 32'h08070605);
        check("full_rw_ovr", 32'(overrun), 32'd0);
        for (int i = 1; i < DEPTH; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("last_word", fifo_rx_rdata, 32'h99030201);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Read on empty.
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("empty_read_rdata", fifo_rx_rdata, 32'h0);
        check("empty_read_level", 32'(rx_level), 32'd0);
        check("empty_read_ovr", 32'(overrun), 32'd0);

        // Threshold interrupt (expected 0 throughout unless the feature is built in).
        rx_thresh = 5'd4;
        for (int i = 0; i < 3; i++) put_word(fill_word(i));
        check("irq_at_3", 32'(rx_thresh_irq), 32'd0);
        put_word(fill_word(3));
`ifdef QSPI_RX_THRESH_IRQ_EN
        check("irq_at_4", 32'(rx_thresh_irq), 32'd1);
`else
        check("irq_off_at_4", 32'(rx_thresh_irq), 32'd0);
`endif
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("irq_after_read", 32'(rx_thresh_irq), 32'd0);
        rx_thresh = 5'd0;
        put_word(fill_word(4));
        put_word(fill_word(5));
        check("irq_thresh0", 32'(rx_thresh_irq), 32'd0);

        // Reset mid-packing: level 5, two bytes pending.
        check("pre_reset_level", 32'(rx_level), 32'd5);
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h5B, 1'b0, 1'b0, 1'b0);
        check("pre_reset_pend", 32'(rx_pend_bytes), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_rdata", fifo_rx_rdata, 32'h0);
        check("rst_level", 32'(rx_level), 32'd0);
        check("rst_pend", 32'(rx_pend_bytes), 32'd0);
        check("rst_empty", 32'(rx_empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        put_word(32'hA4A3A2A1);
        check("post_reset_word", fifo_rx_rdata, 32'hA4A3A2A1);
        check("post_reset_level", 32'(rx_level), 32'd1);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qspi_rx_fifo.md
Name: qspi_rx_fifo

Overview:
- Receive-side buffer between the QSPI FSM/shifter and the CSR block.
- Packs serially received bytes into 32-bit little-endian words and pushes them into a word FIFO.
- The APB side pops words by reading the FIFO_RX data register.
- Reports level, full/empty and sticky overrun to the FIFO_STAT and ERR_STAT registers.

Parameters:
- FIFO_DEPTH, 16, word entries; must be a power of 2, range 2..16.
- DATA_WIDTH, 32, word width; fixed at 4 bytes.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- rx_byte_valid  input  1  one-cycle strobe from the QSPI FSM: rx_byte is valid.
- rx_byte  input  8  received byte.
- rx_flush  input  1  end-of-transfer strobe from the QSPI FSM; pushes a partial word.
- fifo_rx_re  input  1  from APB: one-cycle read strobe on the FIFO_RX data register.
- fifo_rx_rdata  output  DATA_WIDTH  head word (show-ahead) to the APB prdata mux.
- rx_empty  output  1  FIFO empty.
- rx_full  output  1  FIFO full.
- rx_level  output  5  word count, 0..FIFO_DEPTH, to FIFO_STAT.
- rx_pend_bytes  output  2  bytes held in the packer, not yet pushed.
- overrun  output  1  sticky, to ERR_STAT bit 3.
- overrun_clr  input  1  W1C pulse from CSR.
- rx_thresh  input  5  level threshold (used only with the optional feature).
- rx_thresh_irq  output  1  threshold interrupt (optional feature).

Behaviour:

Reset:
- All pointers, count, packer register and byte index, and overrun are 0.
- fifo_rx_rdata=0, rx_empty=1, rx_full=0, rx_level=0, rx_pend_bytes=0, rx_thresh_irq=0.

Packer states (encoded by byte index bidx 0..3):
- EMPTY: bidx=0.
- PARTIAL: bidx=1..3.
- On rx_byte_valid, the byte goes into pack lane bidx ([8*bidx+7:8*bidx]); the first byte lands in [7:0]. bidx increments.
- At bidx=3 with rx_byte_valid, the completed word is pushed the same cycle. bidx returns to 0 and the pack register clears.
- rx_flush with bidx!=0: pushes the packed word with unused upper lanes zero; bidx returns to 0.
- rx_flush with bidx=0: no push.
- rx_byte_valid and rx_flush in the same cycle: the byte is included first, then the resulting word is pushed (exactly one push).
- rx_pend_bytes = bidx.

Word FIFO:
- A push writes mem[wr_ptr], and wr_ptr advances (wraps modulo FIFO_DEPTH).
- fifo_rx_rdata is combinational: mem[rd_ptr] when not empty, otherwise 0.
- fifo_rx_re when not empty: rd_ptr advances; the next word is visible the cycle after.
- fifo_rx_re when empty: ignored; no error, rdata=0.
- Push and read in the same cycle: both happen, count unchanged. This holds even when full, so the push is accepted.
- Push when full without a simultaneous read: the word is dropped, overrun<=1, pointers unchanged.
- Packer state still resets after a dropped word.

Counts and flags:
- count width clog2(FIFO_DEPTH)+1; rx_level is count zero-extended to 5 bits.
- rx_full = (count==FIFO_DEPTH); rx_empty = (count==0).

overrun:
- Set has priority over overrun_clr in the same cycle.
- Cleared only by overrun_clr or by reset.

Latency:
- A byte received at cycle N that completes a word makes the word visible on fifo_rx_rdata at cycle N+1, with rx_level incremented at N+1.

Optional Feature:
- Macro: QSPI_RX_THRESH_IRQ_EN.
- Defined: rx_thresh_irq is a registered output. At each clock it is set to (rx_thresh!=0 && next-cycle count >= rx_thresh), so it is level-sensitive and drops when reads lower the count below the threshold.
- Not defined: rx_thresh_irq is tied 0, rx_thresh is ignored, and no threshold flop exists.

Decomposition:
- Package qspi_rx_pkg holds:
  - BYTES_PER_WORD=4;
  - the default depth constant;
  - the level width function/constant;
  - the ERR_STAT overrun bit index (3).
- One natural sub-module: qspi_rx_packer (bidx counter, pack register, push strobe, push word). The FIFO storage and flags stay in the top module.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 -> one push; rdata=0x44332211, rx_level=1, rx_pend_bytes=0.
- Bytes 0xAA,0xBB then rx_flush -> rdata=0x0000BBAA.
- rx_flush alone at bidx=0 -> no push, level stays 0.
- Byte 0xCC in the same cycle as rx_flush at bidx=1 (held 0xAA) -> single push of 0x0000CCAA.
- Fill 16 words, then push a 17th -> word dropped, overrun=1, level=16.
  - Then read all 16 -> data in order, no corruption.
  - Then overrun_clr -> overrun=0.
- At full, push plus fifo_rx_re in the same cycle -> level stays 16, head advances, overrun stays 0.
- Read on empty -> rdata=0, level stays 0, no flag.
- Reset mid-packing (bidx=2, level=5) -> all outputs return to reset values; the next 4 bytes form a fresh word.
- With QSPI_RX_THRESH_IRQ_EN and rx_thresh=4:
  - irq rises the cycle level becomes 4;
  - irq falls after a read to 3;
  - with rx_thresh=0, irq never asserts.
